// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions for the program-counter sequencer.
package arch_defs_pkg;

  // Default program-counter width used by the sequencer.
  localparam int ADDR_WIDTH = 8;

  // Branch operation encoding carried on branch_op.
  typedef enum logic [2:0] {
    BR_JMP  = 3'd0,
    BR_JZ   = 3'd1,
    BR_JNZ  = 3'd2,
    BR_JC   = 3'd3,
    BR_JNC  = 3'd4,
    BR_JN   = 3'd5,
    BR_CALL = 3'd6,
    BR_RET  = 3'd7
  } branch_op_t;

  // Sequencer operating states; HALTED and FAULT are only left through reset.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_t;

  // True when the branch condition is satisfied by the sampled flags.
  // CALL and RET are unconditional; their stack checks are done by the caller.
  function automatic logic br_cond(branch_op_t op, logic z, logic c, logic n);
    logic res;
    res = 1'b0;
    case (op)
      BR_JMP:  res = 1'b1;
      BR_JZ:   res = z;
      BR_JNZ:  res = ~z;
      BR_JC:   res = c;
      BR_JNC:  res = ~c;
      BR_JN:   res = n;
      BR_CALL: res = 1'b1;
      BR_RET:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO. Storage is not reset; only the occupancy level is.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW    = $clog2(DEPTH+1);
  // Storage sized to a power of two so the level-based index is always in range.
  localparam int MEM_N = 1 << LW;

  logic [WIDTH-1:0] mem [MEM_N];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  // Top of stack; contents are meaningless while empty.
  assign dout  = mem[level - LW'(1)];

  // Write the pushed entry at the current level.
  always_ff @(posedge clk) begin
    if (push && !full) mem[level] <= din;
  end

  // Track occupancy; push wins if both are requested, overflow/underflow ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                level <= '0;
    else if (push && !full)   level <= level + LW'(1);
    else if (pop && !empty)   level <= level - LW'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with conditional branches, call/return stack,
// halt and sticky stack-fault handling.
module pc_sequencer #(
  parameter int ADDR_WIDTH   = arch_defs_pkg::ADDR_WIDTH,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pc_inc,
  input  logic                             branch_req,
  input  arch_defs_pkg::branch_op_t        branch_op,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic                             flag_z,
  input  logic                             flag_c,
  input  logic                             flag_n,
  input  logic                             halt_req,
  output logic [ADDR_WIDTH-1:0]            pc_out,
  output logic                             taken,
  output logic                             halted,
  output logic                             stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp_level
);

  import arch_defs_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] RV = ADDR_WIDTH'(RESET_VECTOR);

  seq_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt, pc_plus1, stk_top;
  logic                  taken_nxt, push, pop, stk_full, stk_empty;

  assign pc_plus1 = pc_out + ADDR_WIDTH'(1);

  lifo_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .level (sp_level)
  );

  // State, PC and taken pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      pc_out <= RV;
      taken  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_out <= pc_nxt;
      taken  <= taken_nxt;
    end
  end

  // Next-state / next-PC: halt > branch > increment > hold while running.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    taken_nxt = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (state == ST_RUN) begin
      if (halt_req) begin
        state_nxt = ST_HALTED;
      end else if (branch_req) begin
        case (branch_op)
          BR_CALL: begin
            if (stk_full) begin
              state_nxt = ST_FAULT;
            end else begin
              push      = 1'b1;
              pc_nxt    = target;
              taken_nxt = 1'b1;
            end
          end
          BR_RET: begin
            if (stk_empty) begin
              state_nxt = ST_FAULT;
            end else begin
              pop       = 1'b1;
              pc_nxt    = stk_top;
              taken_nxt = 1'b1;
            end
          end
          default: begin
            if (br_cond(branch_op, flag_z, flag_c, flag_n)) begin
              pc_nxt    = target;
              taken_nxt = 1'b1;
            end else if (pc_inc) begin
              pc_nxt = pc_plus1;
            end
          end
        endcase
      end else if (pc_inc) begin
        pc_nxt = pc_plus1;
      end
    end
  end

  assign halted    = (state == ST_HALTED);
  assign stack_err = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;
  import arch_defs_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 2;
  localparam int RV    = 0;

  logic            clk, reset;
  logic            pc_inc, branch_req, flag_z, flag_c, flag_n, halt_req;
  branch_op_t      branch_op;
  logic [AW-1:0]   target;
  logic [AW-1:0]   pc_out;
  logic            taken, halted, stack_err;
  logic [1:0]      sp_level;

  int n_cmp, n_err;

  // Reference model: PC as integer, stack as queue, mode 0=run 1=halted 2=fault.
  int m_pc;
  int m_stk[$];
  int m_mode;
  bit m_taken;

  pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .pc_inc(pc_inc), .branch_req(branch_req),
    .branch_op(branch_op), .target(target), .flag_z(flag_z), .flag_c(flag_c),
    .flag_n(flag_n), .halt_req(halt_req), .pc_out(pc_out), .taken(taken),
    .halted(halted), .stack_err(stack_err), .sp_level(sp_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"},        int'(pc_out),    m_pc);
    chk({tag, ".taken"},     int'(taken),     int'(m_taken));
    chk({tag, ".halted"},    int'(halted),    int'(m_mode == 1));
    chk({tag, ".stack_err"}, int'(stack_err), int'(m_mode == 2));
    chk({tag, ".sp_level"},  int'(sp_level),  m_stk.size());
  endtask

  task automatic model_reset();
    m_pc = RV; m_stk.delete(); m_mode = 0; m_taken = 0;
  endtask

  task automatic model_edge();
    bit t;
    m_taken = 0;
    if (m_mode != 0) return;
    if (halt_req) m_mode = 1;
    else if (branch_req) begin
      if (branch_op == BR_CALL) begin
        if (m_stk.size() == DEPTH) m_mode = 2;
        else begin m_stk.push_back((m_pc + 1) % 256); m_pc = int'(target); m_taken = 1; end
      end else if (branch_op == BR_RET) begin
        if (m_stk.size() == 0) m_mode = 2;
        else begin m_pc = m_stk.pop_back(); m_taken = 1; end
      end else begin
        t = (branch_op == BR_JMP) || (branch_op == BR_JZ && flag_z) ||
            (branch_op == BR_JNZ && !flag_z) || (branch_op == BR_JC && flag_c) ||
            (branch_op == BR_JNC && !flag_c) || (branch_op == BR_JN && flag_n);
        if (t) begin m_pc = int'(target); m_taken = 1; end
        else if (pc_inc) m_pc = (m_pc + 1) % 256;
      end
    end else if (pc_inc) m_pc = (m_pc + 1) % 256;
  endtask

  task automatic set_in(bit inc, bit br, branch_op_t o, int tg, bit z, bit c, bit n, bit h);
    pc_inc = inc; branch_req = br; branch_op = o; target = AW'(tg);
    flag_z = z; flag_c = c; flag_n = n; halt_req = h;
  endtask

  // Apply inputs for one cycle, advance model at the edge, check 1 time unit later.
  task automatic step(string tag, bit inc, bit br, branch_op_t o, int tg,
                      bit z, bit c, bit n, bit h);
    set_in(inc, br, o, tg, z, c, n, h);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges, with inputs possibly active.
  task automatic async_reset(string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    #1 reset = 1'b0;
    set_in(0, 0, BR_JMP, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    set_in(0, 0, BR_JMP, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #3 model_reset();
    check_all("por");
    @(posedge clk); #1 reset = 1'b0;

    // Increment and unconditional jump.
    repeat (3) step("inc", 1, 0, BR_JMP, 0, 0, 0, 0, 0);
    chk("inc3_lit", int'(pc_out), 'h03);
    step("jmp", 0, 1, BR_JMP, 'h0A, 0, 0, 0, 0);
    chk("jmp_lit", int'(pc_out), 'h0A);
    chk("jmp_taken_lit", int'(taken), 1);
    step("idle", 0, 0, BR_JMP, 0, 0, 0, 0, 0);
    chk("taken_once_lit", int'(taken), 0);

    // Conditional JZ not taken then taken.
    step("jmp5", 0, 1, BR_JMP, 'h05, 0, 0, 0, 0);
    step("jz_nt", 1, 1, BR_JZ, 'h20, 0, 0, 0, 0);
    chk("jz_nt_lit", int'(pc_out), 'h06);
    step("jmp5b", 0, 1, BR_JMP, 'h05, 0, 0, 0, 0);
    step("jz_t", 1, 1, BR_JZ, 'h20, 1, 0, 0, 0);
    chk("jz_t_lit", int'(pc_out), 'h20);

    // Call / return.
    step("jmp10", 0, 1, BR_JMP, 'h10, 0, 0, 0, 0);
    step("call", 0, 1, BR_CALL, 'h40, 0, 0, 0, 0);
    chk("call_lit", int'(pc_out), 'h40);
    step("ret", 1, 1, BR_RET, 'h77, 0, 0, 0, 0);
    chk("ret_lit", int'(pc_out), 'h11);

    // Overflow: third nested call faults and freezes.
    step("c1", 0, 1, BR_CALL, 'h50, 0, 0, 0, 0);
    step("c2", 0, 1, BR_CALL, 'h60, 0, 0, 0, 0);
    step("c3", 0, 1, BR_CALL, 'h70, 0, 0, 0, 0);
    chk("ovf_err_lit", int'(stack_err), 1);
    chk("ovf_pc_lit", int'(pc_out), 'h60);
    chk("ovf_sp_lit", int'(sp_level), 2);
    step("fault_hold", 1, 1, BR_JMP, 'h33, 0, 0, 0, 0);
    async_reset("rst1");
    // Underflow from empty stack.
    step("ret_empty", 0, 1, BR_RET, 0, 0, 0, 0, 0);
    chk("unf_err_lit", int'(stack_err), 1);
    async_reset("rst2");

    // Wrap and halt.
    step("jmpff", 0, 1, BR_JMP, 'hFF, 0, 0, 0, 0);
    step("wrap", 1, 0, BR_JMP, 0, 0, 0, 0, 0);
    chk("wrap_lit", int'(pc_out), 'h00);
    step("halt", 1, 1, BR_JMP, 'h44, 0, 0, 0, 1);
    chk("halt_lit", int'(halted), 1);
    step("halt_hold", 1, 1, BR_CALL, 'h55, 0, 0, 0, 0);
    async_reset("rst3");

    // Reset landing in the middle of a call cycle.
    step("pre_call", 0, 1, BR_CALL, 'h30, 0, 0, 0, 0);
    set_in(0, 1, BR_CALL, 'h90, 0, 0, 0, 0);
    async_reset("rst_mid_call");
    chk("mid_call_sp_lit", int'(sp_level), 0);
    step("post_rst", 1, 0, BR_JMP, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional halts and asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) begin
        set_in($urandom_range(1), 1, branch_op_t'($urandom_range(7)), $urandom_range(255),
               0, 0, 0, 0);
        async_reset("rnd_rst");
      end
      step("rnd", bit'($urandom_range(1)), bit'($urandom_range(99) < 40),
           branch_op_t'($urandom_range(7)), int'($urandom_range(255)),
           bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)),
           bit'($urandom_range(99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program-counter and target width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-003 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc_inc  input  1  advance PC by one.
REQ-007 SHALL have port branch_req  input  1  one-cycle strobe, evaluate branch_op.
REQ-008 SHALL have port branch_op  input  3  branch_op_t: BR_JMP, BR_JZ, BR_JNZ, BR_JC, BR_JNC, BR_JN, BR_CALL, BR_RET.
REQ-009 SHALL have port target  input  ADDR_WIDTH  branch destination.
REQ-010 SHALL have ports flag_z, flag_c, flag_n  input  1 each  ALU flags, sampled with branch_req.
REQ-011 SHALL have port halt_req  input  1  enter HALTED.
REQ-012 SHALL have port pc_out  output  ADDR_WIDTH  current PC, registered.
REQ-013 SHALL have port taken  output  1  one-cycle pulse, branch taken at that edge.
REQ-014 SHALL have port halted  output  1  high in HALTED.
REQ-015 SHALL have port stack_err  output  1  sticky, high in FAULT.
REQ-016 SHALL have port sp_level  output  $clog2(STACK_DEPTH+1)  current stack occupancy.

Function
REQ-017 SHALL implement states RUN, HALTED, FAULT; only reset leaves HALTED or FAULT.
REQ-018 In RUN, per-cycle priority SHALL be halt_req > branch_req > pc_inc > hold.
REQ-019 pc_inc alone SHALL set pc_out to pc_out+1 modulo 2^ADDR_WIDTH at the next edge (max wraps to 0).
REQ-020 Taken branch SHALL load target into pc_out at the next edge, latency one cycle; concurrent pc_inc ignored.
REQ-021 Condition: JMP/CALL/RET unconditional; JZ z=1; JNZ z=0; JC c=1; JNC c=0; JN n=1.
REQ-022 Not-taken conditional branch SHALL behave as pc_inc (advance by one if pc_inc high, else hold).
REQ-023 BR_CALL SHALL push pc_out+1 (mod 2^ADDR_WIDTH) onto stack, increment sp_level, load target.
REQ-024 BR_RET SHALL pop top entry into pc_out, decrement sp_level; target ignored.
REQ-025 CALL with sp_level==STACK_DEPTH SHALL not push or jump; SHALL set stack_err and enter FAULT.
REQ-026 RET with sp_level==0 SHALL not pop or jump; SHALL set stack_err and enter FAULT.
REQ-027 taken SHALL be high for exactly the cycle after a taken branch edge, including CALL/RET; low on faults.
REQ-028 halt_req in RUN SHALL freeze pc_out, set halted next edge; concurrent branch_req and pc_inc ignored.
REQ-029 In HALTED and FAULT, pc_out, stack, sp_level SHALL hold; all requests ignored; taken low.

Reset
REQ-030 reset SHALL asynchronously force pc_out=RESET_VECTOR, sp_level=0, taken=0, halted=0, stack_err=0, state RUN.
REQ-031 Reset mid-branch or mid-CALL SHALL discard the pending operation; stack contents need not clear.

Structure
REQ-032 branch_op_t and the sequencer state enum SHALL live in arch_defs_pkg; ADDR_WIDTH default SHALL come from its ADDR_WIDTH constant.
REQ-033 Return stack SHALL be sub-module lifo_stack (params WIDTH, DEPTH; push, pop, full, empty, level).

Verification
REQ-034 Reset, pc_inc 3 cycles -> pc_out 0x03; branch_req BR_JMP target 0x0A -> pc_out 0x0A next edge, taken pulses once.
REQ-035 BR_JZ target 0x20 with z=0, pc_inc=1 at pc 0x05 -> pc_out 0x06, taken 0; repeat with z=1 -> pc_out 0x20.
REQ-036 At pc 0x10 BR_CALL 0x40 -> pc_out 0x40, sp_level 1; BR_RET -> pc_out 0x11, sp_level 0.
REQ-037 STACK_DEPTH=2: three nested CALLs -> third sets stack_err, pc_out holds, sp_level 2; RET at reset-empty -> stack_err.
REQ-038 pc_out 0xFF plus pc_inc -> 0x00; halt_req with simultaneous BR_JMP -> halted=1, pc_out unchanged.
REQ-039 reset asserted mid-CALL between edges -> pc_out=RESET_VECTOR immediately, sp_level 0, flags clear.
